// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and bit-timing math.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;

    // One bit lasts calc_bit_div()+1 clocks.
    function automatic int calc_bit_div(input int clk_hz, input int baud);
        return (clk_hz / baud) - 1;
    endfunction

    function automatic int calc_half_div(input int bit_div);
        return bit_div / 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Power-of-two receive FIFO with wrap-around pointers, occupancy count and
// an overrun pulse when a push is refused because the buffer is full.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     nRst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overrun_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             overrun_q;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign do_push = push_i & (~full | do_pop);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            overrun_q <= push_i & full & ~do_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Storage is not reset; masking the head while empty gives a clean zero output.
    assign data_o    = empty ? '0 : mem_q[rd_ptr_q];
    assign valid_o   = ~empty;
    assign count_o   = count_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM, framing/parity
// checks and a receive FIFO. Define UART_RX_PARITY_EN to add a parity bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD        = 9600,
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int PARITY_ODD  = 0
) (
    input  logic                          clk,
    input  logic                          nRst,
    input  logic                          rx_i,
    output logic [DATA_BITS-1:0]          rx_data_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic                          frame_err_o,
    output logic                          parity_err_o,
    output logic                          overrun_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int BIT_DIV  = calc_bit_div(CLK_FREQ_HZ, BAUD);
    localparam int HALF_DIV = calc_half_div(BIT_DIV);
    localparam int CNT_W    = (BIT_DIV < 1) ? 1 : $clog2(BIT_DIV + 1);
    localparam int BCNT_W   = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0]  CNT_BIT   = CNT_W'(BIT_DIV);
    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(HALF_DIV);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx: DATA_BITS must be in 5..9");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx: FIFO_DEPTH must be a power of two >= 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
        $error("uart_rx: PARITY_ODD must be 0 or 1");
    end

    logic [1:0]           sync_q;
    logic                 rx_s;
    rx_state_e            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BCNT_W-1:0]    bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 frame_err_q;
    logic                 bit_tick;
    logic                 par_bad;
    logic                 push;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_INV = 1'(PARITY_ODD);
    logic par_bad_q;
    logic parity_err_q;
    assign par_bad      = par_bad_q;
    assign parity_err_o = parity_err_q;
`else
    assign par_bad      = 1'b0;
    assign parity_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    assign rx_s     = sync_q[1];
    assign bit_tick = (cnt_q == CNT_BIT);
    // Push decodes the stop-bit sample directly so the FIFO writes on that same edge.
    assign push     = (state_q == ST_STOP) & bit_tick & rx_s & ~par_bad;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    cnt_q     <= '0;
                    bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_q <= 1'b0;
`endif
                    if (!rx_s) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q   <= '0;
                        state_q <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BCNT_LAST) begin
                            bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                            state_q   <= ST_PARITY;
`else
                            state_q   <= ST_STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BCNT_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_tick) begin
                        cnt_q     <= '0;
                        par_bad_q <= rx_s ^ (^shift_q) ^ PAR_INV;
                        state_q   <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_tick) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_WAIT_IDLE;
                        end else begin
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= par_bad_q;
`endif
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_IDLE: begin
                    // A held-low line (break) must return high before a new start is accepted.
                    cnt_q <= '0;
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign frame_err_o = frame_err_q;

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .nRst      (nRst),
        .push_i    (push),
        .data_i    (shift_q),
        .pop_i     (rx_ready_i),
        .data_o    (rx_data_o),
        .valid_o   (rx_valid_o),
        .count_o   (fifo_count_o),
        .overrun_o (overrun_o)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit by bit, a character-level
// model predicts deliveries and error pulses, and a monitor checks the outputs.
module tb_uart_rx;

    localparam int BIT_CLKS = 10;
    localparam int DEPTH    = 4;
    localparam bit PAR_ODD  = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       rx_i = 1'b1;
    logic       rx_ready_i = 1'b0;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       frame_err_o;
    logic       parity_err_o;
    logic       overrun_o;
    logic [2:0] fifo_count_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int exp_frame = 0, exp_par = 0, exp_ovr = 0;
    int seen_frame = 0, seen_par = 0, seen_ovr = 0, seen_valid = 0;
    bit rand_ready = 1'b0;

    uart_rx #(
        .CLK_FREQ_HZ (1000),
        .BAUD        (100),
        .DATA_BITS   (8),
        .FIFO_DEPTH  (DEPTH),
        .PARITY_ODD  (0)
    ) dut (
        .clk          (clk),
        .nRst         (nRst),
        .rx_i         (rx_i),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .overrun_o    (overrun_o),
        .fifo_count_o (fifo_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and tallies error pulses.
    initial begin : monitor
        logic [7:0] prev_data;
        bit         prev_hold;
        prev_hold = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (!nRst) begin
                prev_hold = 1'b0;
            end else begin
                if (frame_err_o)  seen_frame++;
                if (parity_err_o) seen_par++;
                if (overrun_o)    seen_ovr++;
                if (rx_valid_o)   seen_valid++;
                if (prev_hold && rx_valid_o) chk("head_stable", rx_data_o, prev_data);
                if (rx_valid_o && rx_ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_char: got 0x%0h, want no character", rx_data_o);
                    end else begin
                        chk("rx_data", rx_data_o, exp_q.pop_front());
                    end
                end
                prev_hold = rx_valid_o && !rx_ready_i;
                prev_data = rx_data_o;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) rx_ready_i = 1'($urandom_range(0, 1));
        end
    endtask

    // Drives one frame; the model decides the outcome just before the stop bit.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_flip,
                              input int hold_low, input int idle);
        logic par;
        par = 1'($countones(d) % 2) ^ PAR_ODD ^ par_flip;
        rx_i = 1'b0;
        tick(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            tick(BIT_CLKS);
        end
        if (PAR_EN) begin
            rx_i = par;
            tick(BIT_CLKS);
        end
        if (!stop_ok)                 exp_frame++;
        else if (PAR_EN && par_flip)  exp_par++;
        else if (exp_q.size() >= DEPTH) exp_ovr++;
        else                          exp_q.push_back(d);
        rx_i = stop_ok;
        tick(BIT_CLKS + (stop_ok ? 0 : hold_low));
        rx_i = 1'b1;
        tick(idle);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_frame_pulses"},  seen_frame, exp_frame);
        chk({tag, "_parity_pulses"}, seen_par,   exp_par);
        chk({tag, "_overrun_pulses"}, seen_ovr,  exp_ovr);
        chk({tag, "_fifo_count"},    int'(fifo_count_o), exp_q.size());
        chk({tag, "_valid"},         int'(rx_valid_o), int'(exp_q.size() != 0));
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick(1);
            c++;
        end
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin : stimulus
        int v0;
        logic [7:0] d;
        bit bad_stop, flip;

        nRst = 1'b0;
        rx_i = 1'b1;
        rx_ready_i = 1'b0;
        tick(3);
        chk("rst_valid", rx_valid_o, 0);
        chk("rst_data", rx_data_o, 0);
        chk("rst_count", fifo_count_o, 0);
        chk("rst_frame_err", frame_err_o, 0);
        chk("rst_parity_err", parity_err_o, 0);
        chk("rst_overrun", overrun_o, 0);
        nRst = 1'b1;
        tick(5);

        // Single character, consumer always ready.
        rx_ready_i = 1'b1;
        v0 = seen_valid;
        send_frame(8'h55, 1'b1, 1'b0, 0, 20);
        chk("c55_valid_cycles", seen_valid - v0, 1);
        chk("c55_drained", exp_q.size(), 0);
        check_counts("c55");

        // Short low glitch must not start a frame.
        v0 = seen_valid;
        rx_i = 1'b0;
        tick(3);
        rx_i = 1'b1;
        tick(30);
        chk("glitch_no_valid", seen_valid - v0, 0);
        check_counts("glitch");

        // Fill the FIFO with the consumer stalled, one extra character overruns.
        rx_ready_i = 1'b0;
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, 1'b0, 0, 3);
        tick(5);
        chk("full_count", fifo_count_o, DEPTH);
        check_counts("overrun");
        rx_ready_i = 1'b1;
        wait_drain("overrun", 50);
        tick(2);
        check_counts("overrun_drain");

        // Low stop bit followed by a break, then a clean character.
        send_frame(8'hC4, 1'b0, 1'b0, 30, 5);
        check_counts("frame");
        send_frame(8'hA3, 1'b1, 1'b0, 0, 20);
        check_counts("after_frame");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 0, 20);
        check_counts("parity_bad");
        send_frame(8'h07, 1'b1, 1'b0, 0, 20);
        check_counts("parity_good");
`endif

        // Reset in the middle of the data bits with a character already buffered.
        rx_ready_i = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 0, 5);
        chk("pre_reset_count", fifo_count_o, 1);
        d = 8'h3C;
        rx_i = 1'b0;
        tick(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            rx_i = d[i];
            tick(BIT_CLKS);
        end
        nRst = 1'b0;
        #2;
        chk("async_rst_valid", rx_valid_o, 0);
        chk("async_rst_data", rx_data_o, 0);
        chk("async_rst_count", fifo_count_o, 0);
        chk("async_rst_errs", {frame_err_o, parity_err_o, overrun_o}, 0);
        exp_q.delete();
        rx_i = 1'b1;
        tick(3);
        nRst = 1'b1;
        tick(5);
        rx_ready_i = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b0, 0, 20);
        check_counts("after_reset");

        // Random characters with occasional framing/parity faults and a random consumer.
        rand_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom_range(0, 255));
            bad_stop = ($urandom_range(0, 7) == 0);
            flip = PAR_EN && ($urandom_range(0, 5) == 0);
            send_frame(d, !bad_stop, flip, 0, $urandom_range(2, 15));
        end
        rand_ready = 1'b0;
        rx_ready_i = 1'b1;
        wait_drain("random", 100);
        tick(2);
        check_counts("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal range 5..9, character width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, power of two, at least 2, receive buffer entries.
REQ-005 SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity.
REQ-006 SHALL have port clk, input, 1 bit: the only clock, all logic on its rising edge.
REQ-007 SHALL have port nRst, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port rx_i, input, 1 bit: asynchronous serial line, idle high.
REQ-009 SHALL have port rx_data_o, output, DATA_BITS: FIFO head character.
REQ-010 SHALL have port rx_valid_o, output, 1 bit: FIFO not empty.
REQ-011 SHALL have port rx_ready_i, input, 1 bit: consumer accepts the head.
REQ-012 SHALL have port frame_err_o, output, 1 bit: one-cycle pulse on stop bit sampled low.
REQ-013 SHALL have port parity_err_o, output, 1 bit: one-cycle pulse on parity mismatch.
REQ-014 SHALL have port overrun_o, output, 1 bit: one-cycle pulse when a good character is dropped because the FIFO is full.
REQ-015 SHALL have port fifo_count_o, output, $clog2(FIFO_DEPTH)+1 bits: current occupancy.

Function
REQ-016 SHALL pass rx_i through a 2-flop synchroniser; FSM sees only the synchronised value.
REQ-017 SHALL derive BIT_DIV = CLK_FREQ_HZ/BAUD - 1 and HALF_DIV = BIT_DIV/2 (integer); one bit lasts BIT_DIV+1 clocks.
REQ-018 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-019 SHALL move IDLE->START, baud counter cleared, on synchronised line low.
REQ-020 SHALL in START, on counter==HALF_DIV, go to DATA if line still low; otherwise treat it as a glitch and return to IDLE. Either way the counter is cleared.
REQ-021 SHALL in DATA sample on each counter==BIT_DIV and shift in LSB first; after DATA_BITS samples go to PARITY (macro on) or STOP.
REQ-022 SHALL in PARITY sample one bit and compare it against the XOR of the data bits, inverted when PARITY_ODD=1; record the mismatch; go to STOP.
REQ-023 SHALL in STOP sample at counter==BIT_DIV:
  - line high, parity ok: push character, return to IDLE.
  - line high, parity bad: pulse parity_err_o, discard, return to IDLE.
  - line low: pulse frame_err_o, discard, go to WAIT_IDLE (frame error takes priority over parity error).
REQ-024 SHALL leave WAIT_IDLE for IDLE only when the synchronised line is high (break handling).
REQ-025 SHALL assert rx_valid_o the cycle after the stop-bit sample of a pushed character; rx_data_o holds the head stable while rx_valid_o=1 and rx_ready_i=0.
REQ-026 SHALL pop on rx_valid_o & rx_ready_i; rx_ready_i while empty has no effect.
REQ-027 SHALL, on push and pop in the same cycle, perform both; count is unchanged and there is no overrun even when full.
REQ-028 SHALL, on push while full without pop, drop the new character, pulse overrun_o, and leave FIFO contents unchanged.
REQ-029 SHALL use a wrap-around FIFO pointer width of $clog2(FIFO_DEPTH).

Reset
REQ-030 SHALL, on nRst low, immediately force: FSM IDLE, counters 0, FIFO empty, synchroniser flops 1, rx_valid_o=0, rx_data_o=0, all error pulses 0, fifo_count_o=0.
REQ-031 SHALL abandon any character in progress at reset mid-frame and never push it.

Configuration
REQ-032 SHALL honour macro UART_RX_PARITY_EN:
  - defined: PARITY state present; each frame is start + DATA_BITS + parity + stop.
  - undefined: PARITY state and logic removed; frame is start + DATA_BITS + stop; parity_err_o tied 0; port list unchanged.

Structure
REQ-033 SHALL place the FSM state enum and the BIT_DIV/HALF_DIV calculation function in shared package uart_pkg.
REQ-034 SHALL implement the buffer as sub-module uart_rx_fifo, parametrised by width and depth.

Verification
Bench parameters for REQ-035..REQ-040: CLK_FREQ_HZ=1000, BAUD=100, so BIT_DIV=9.
REQ-035 SHALL cover: send 0x55, 8N1, rx_ready_i=1 -> rx_valid_o for one cycle with rx_data_o=0x55; no error pulses.
REQ-036 SHALL cover: 3-clock low glitch on rx_i -> FSM returns to IDLE; no push, no error.
REQ-037 SHALL cover: rx_ready_i=0, send 5 characters 0x01..0x05 with FIFO_DEPTH=4 -> fifo_count_o=4; overrun_o pulses once; draining yields 0x01..0x04.
REQ-038 SHALL cover: stop bit driven low, then line held low 30 clocks -> frame_err_o pulses once; no push; next valid 0xA3 is received correctly.
REQ-039 SHALL cover, with UART_RX_PARITY_EN and PARITY_ODD=0: 0x07 with parity bit 0 -> parity_err_o pulse, discard; 0x07 with parity bit 1 -> rx_data_o=0x07.
REQ-040 SHALL cover: nRst asserted mid-DATA -> all outputs at reset values; a subsequent 0x3C is received intact.
